// File: rtl/decode_stage.sv
// decode_stage: decodes up to DECODE_WIDTH RV32I instructions per cycle into one registered
// stage feeding rename. Define DECODE_SFB_EN to build the short-forward-branch shadow tracker.
package decode_pkg;
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2, IMM_B = 3'd3, IMM_U = 3'd4, IMM_J = 3'd5
    } imm_t;
    typedef enum logic [1:0] {EXU_ALU = 2'd0, EXU_BRU = 2'd1, EXU_LSU = 2'd2, EXU_SYS = 2'd3} exu_t;
    typedef struct packed {
        logic       legal;
        logic [3:0] uop;
        exu_t       exu;
        logic       rd_we;
        logic       rs1_re;
        logic       rs2_re;
        imm_t       imm_type;
        logic       branch;
        logic       jump;
    } ctrl_t;
    typedef struct packed {
        logic        valid;
        ctrl_t       ctrl;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] btarget;
        logic        shadowed;
        logic        sfb;
    } lane_t;
endpackage

module decode_stage
    import decode_pkg::*;
#(
    parameter int DECODE_WIDTH = 2,
    parameter int MAX_SHADOW   = 3,
    parameter int CNT_W        = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_pc,
    input  logic [DECODE_WIDTH-1:0]      in_lane_valid,
    input  logic [32*DECODE_WIDTH-1:0]   in_instr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DECODE_WIDTH-1:0]      out_lane_valid,
    output ctrl_t [DECODE_WIDTH-1:0]     out_ctrl,
    output logic [5*DECODE_WIDTH-1:0]    out_rd,
    output logic [5*DECODE_WIDTH-1:0]    out_rs1,
    output logic [5*DECODE_WIDTH-1:0]    out_rs2,
    output logic [32*DECODE_WIDTH-1:0]   out_imm,
    output logic [32*DECODE_WIDTH-1:0]   out_btarget,
    output logic [DECODE_WIDTH-1:0]      out_shadowed,
    output logic [DECODE_WIDTH-1:0]      out_sfb
);
    // ALU uops are {alt, funct3}; BRU/LSU uops reuse funct3 with these extras.
    localparam logic [3:0] UOP_LUI   = 4'b1010;
    localparam logic [3:0] UOP_AUIPC = 4'b1011;
    localparam logic [3:0] UOP_JAL   = 4'b1000;
    localparam logic [3:0] UOP_JALR  = 4'b1001;

    if ((2 ** CNT_W) <= MAX_SHADOW || DECODE_WIDTH < 1 || DECODE_WIDTH > 4) begin : g_bad_cfg
        $error("decode_stage: unsupported DECODE_WIDTH / CNT_W / MAX_SHADOW combination");
    end

    function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
        ctrl_t      c;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = instr[14:12];
        f7 = instr[31:25];
        c  = '0;
        case (instr[6:0])
            7'b0110111, 7'b0010111: begin
                c.legal = 1'b1; c.exu = EXU_ALU; c.rd_we = 1'b1; c.imm_type = IMM_U;
                c.uop   = instr[5] ? UOP_LUI : UOP_AUIPC;
            end
            7'b1101111: begin
                c.legal = 1'b1; c.exu = EXU_BRU; c.rd_we = 1'b1; c.imm_type = IMM_J;
                c.uop   = UOP_JAL; c.jump = 1'b1;
            end
            7'b1100111: begin
                c.legal = (f3 == 3'd0); c.exu = EXU_BRU; c.rd_we = 1'b1; c.rs1_re = 1'b1;
                c.imm_type = IMM_I; c.uop = UOP_JALR; c.jump = 1'b1;
            end
            7'b1100011: begin
                c.legal = (f3[2:1] != 2'b01); c.exu = EXU_BRU; c.rs1_re = 1'b1; c.rs2_re = 1'b1;
                c.imm_type = IMM_B; c.uop = {1'b0, f3}; c.branch = 1'b1;
            end
            7'b0000011: begin
                c.legal = (f3 != 3'd3) && (f3 < 3'd6); c.exu = EXU_LSU; c.rd_we = 1'b1;
                c.rs1_re = 1'b1; c.imm_type = IMM_I; c.uop = {1'b0, f3};
            end
            7'b0100011: begin
                c.legal = (f3 < 3'd3); c.exu = EXU_LSU; c.rs1_re = 1'b1; c.rs2_re = 1'b1;
                c.imm_type = IMM_S; c.uop = {1'b1, f3};
            end
            7'b0010011: begin
                c.legal = (f3 == 3'd1) ? (f7 == 7'd0) :
                          (f3 == 3'd5) ? (f7 == 7'd0 || f7 == 7'h20) : 1'b1;
                c.exu = EXU_ALU; c.rd_we = 1'b1; c.rs1_re = 1'b1; c.imm_type = IMM_I;
                c.uop = {(f3 == 3'd5) && instr[30], f3};
            end
            7'b0110011: begin
                c.legal = (f7 == 7'd0) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                c.exu = EXU_ALU; c.rd_we = 1'b1; c.rs1_re = 1'b1; c.rs2_re = 1'b1;
                c.imm_type = IMM_NONE; c.uop = {instr[30], f3};
            end
            7'b0001111, 7'b1110011: begin
                c.legal = 1'b1; c.exu = EXU_SYS;
            end
            default: c = '0;
        endcase
        if (c.legal) return c;
        else         return '0;
    endfunction

    function automatic logic [31:0] expand_imm(input imm_t t, input logic [31:0] i);
        case (t)
            IMM_I:   return {{20{i[31]}}, i[31:20]};
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   return {i[31:12], 12'd0};
            IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    lane_t [DECODE_WIDTH-1:0] dec;
    lane_t [DECODE_WIDTH-1:0] stage_d, stage_q;
    logic                     out_valid_d, out_valid_q;
    logic                     accept;

`ifdef DECODE_SFB_EN
    localparam logic [31:0]      SFB_MAX_OFF = 32'(4 * (MAX_SHADOW + 1));
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    logic [CNT_W-1:0] shadow_cnt_d, shadow_cnt_q, run_cnt;

    function automatic logic shadowable(input ctrl_t c);
        return c.legal && (c.exu == EXU_ALU);
    endfunction
`endif

    // Per-lane decode plus the in-order shadow walk carrying the running count
    always_comb begin : decode_lanes
        logic [31:0] instr;
        logic [31:0] pc;
        ctrl_t       c;
        dec = '0;
`ifdef DECODE_SFB_EN
        run_cnt = shadow_cnt_q;
`endif
        for (int l = 0; l < DECODE_WIDTH; l++) begin
            instr = in_instr[32*l +: 32];
            pc    = in_pc + (32'(l) << 2);
            c     = decode_ctrl(instr);
            if (in_lane_valid[l]) begin
                dec[l].valid   = 1'b1;
                dec[l].ctrl    = c;
                dec[l].rd      = c.rd_we  ? instr[11:7]  : 5'd0;
                dec[l].rs1     = c.rs1_re ? instr[19:15] : 5'd0;
                dec[l].rs2     = c.rs2_re ? instr[24:20] : 5'd0;
                dec[l].imm     = expand_imm(c.imm_type, instr);
                dec[l].btarget = (c.branch || c.imm_type == IMM_J) ? pc + dec[l].imm : 32'd0;
`ifdef DECODE_SFB_EN
                // A non-shadowable lane (branches included) kills the shadow before any new SFB starts.
                dec[l].shadowed = (run_cnt != '0) && shadowable(c);
                run_cnt         = dec[l].shadowed ? run_cnt - CNT_ONE : '0;
                dec[l].sfb      = c.branch && !dec[l].imm[31] && (dec[l].imm > 32'd4) &&
                                  (dec[l].imm <= SFB_MAX_OFF);
                run_cnt         = dec[l].sfb ? dec[l].imm[CNT_W+1:2] - CNT_ONE : run_cnt;
`endif
            end else begin
                dec[l] = '0;
            end
        end
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Next state: flush wins, then accept, then a consumed bundle drops valid, else hold
    always_comb begin
        out_valid_d = out_valid_q;
        stage_d     = stage_q;
`ifdef DECODE_SFB_EN
        shadow_cnt_d = shadow_cnt_q;
`endif
        if (flush) begin
            out_valid_d = 1'b0;
            stage_d     = '0;
`ifdef DECODE_SFB_EN
            shadow_cnt_d = '0;
`endif
        end else if (accept) begin
            out_valid_d = 1'b1;
            stage_d     = dec;
`ifdef DECODE_SFB_EN
            shadow_cnt_d = run_cnt;
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Stage registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            stage_q     <= '0;
`ifdef DECODE_SFB_EN
            shadow_cnt_q <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            stage_q     <= stage_d;
`ifdef DECODE_SFB_EN
            shadow_cnt_q <= shadow_cnt_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    for (genvar l = 0; l < DECODE_WIDTH; l++) begin : g_out
        assign out_lane_valid[l]       = stage_q[l].valid;
        assign out_ctrl[l]             = stage_q[l].ctrl;
        assign out_rd[5*l +: 5]        = stage_q[l].rd;
        assign out_rs1[5*l +: 5]       = stage_q[l].rs1;
        assign out_rs2[5*l +: 5]       = stage_q[l].rs2;
        assign out_imm[32*l +: 32]     = stage_q[l].imm;
        assign out_btarget[32*l +: 32] = stage_q[l].btarget;
        assign out_shadowed[l]         = stage_q[l].shadowed;
        assign out_sfb[l]              = stage_q[l].sfb;
    end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (DECODE_WIDTH=2): vector table plus hand sequences for
// backpressure, cross-bundle shadows, shadow cancel and flush.
module tb_decode_stage;
    import decode_pkg::*;

`ifdef DECODE_SFB_EN
    localparam logic SFB_ON = 1'b1;
`else
    localparam logic SFB_ON = 1'b0;
`endif

    localparam logic [31:0] ADDI5  = 32'h00500093;
    localparam logic [31:0] LUI    = 32'h12345137;
    localparam logic [31:0] ADD    = 32'h002081B3;
    localparam logic [31:0] XOR    = 32'h0020C233;
    localparam logic [31:0] LW     = 32'h0000A283;
    localparam logic [31:0] BEQ8   = 32'h00208463;
    localparam logic [31:0] BEQ12  = 32'h00208663;
    localparam logic [31:0] BNE16  = 32'h00209863;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] in_pc;
    logic [1:0]  in_lane_valid;
    logic [63:0] in_instr;
    logic [1:0]  out_lane_valid, out_shadowed, out_sfb;
    ctrl_t [1:0] out_ctrl;
    logic [9:0]  out_rd, out_rs1, out_rs2;
    logic [63:0] out_imm, out_btarget;

    int n_checks = 0;
    int n_fail   = 0;

    decode_stage #(.DECODE_WIDTH(2), .MAX_SHADOW(3), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_lane_valid(in_lane_valid), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane_valid(out_lane_valid),
        .out_ctrl(out_ctrl), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_btarget(out_btarget), .out_shadowed(out_shadowed),
        .out_sfb(out_sfb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  lv;
        logic [31:0] pc, i0, i1;
        logic [1:0]  legal;
        logic [31:0] imm0, imm1, bt0, bt1;
        logic [9:0]  rd;
        logic [1:0]  sh, sfb;
    } vec_t;
    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] lv, input logic [31:0] pc, input logic [31:0] i0,
                        input logic [31:0] i1);
        in_valid = 1'b1; in_lane_valid = lv; in_pc = pc; in_instr = {i1, i0};
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_sfb(input string name, input logic [1:0] sh, input logic [1:0] sfb);
        chk({name, "_shadowed"}, 64'(out_shadowed), 64'(sh & {2{SFB_ON}}));
        chk({name, "_sfb"}, 64'(out_sfb), 64'(sfb & {2{SFB_ON}}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b11, 32'h100, 32'hFFF08093, 32'h0020A423, 2'b11, 32'hFFFFFFFF, 32'd8,
                    32'd0, 32'd0, {5'd0, 5'd1}, 2'b00, 2'b00};
        vecs[1] = '{2'b11, 32'h200, 32'h00001197, 32'h010000EF, 2'b11, 32'h00001000, 32'd16,
                    32'd0, 32'h214, {5'd1, 5'd3}, 2'b00, 2'b00};
        vecs[2] = '{2'b11, 32'h100, BEQ8, ADDI5, 2'b11, 32'd8, 32'd5,
                    32'h108, 32'd0, {5'd1, 5'd0}, 2'b10, 2'b01};
        vecs[3] = '{2'b11, 32'h300, 32'hFE000CE3, ADD, 2'b11, 32'hFFFFFFF8, 32'd0,
                    32'h2F8, 32'd0, {5'd3, 5'd0}, 2'b00, 2'b00};
        vecs[4] = '{2'b11, 32'h400, 32'h00208263, ADD, 2'b11, 32'd4, 32'd0,
                    32'h404, 32'd0, {5'd3, 5'd0}, 2'b00, 2'b00};
        vecs[5] = '{2'b11, 32'h500, 32'h00208A63, ADD, 2'b11, 32'd20, 32'd0,
                    32'h514, 32'd0, {5'd3, 5'd0}, 2'b00, 2'b00};
        vecs[6] = '{2'b10, 32'h600, ADDI5, 32'h00000000, 2'b00, 32'd0, 32'd0,
                    32'd0, 32'd0, 10'd0, 2'b00, 2'b00};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_pc = 32'd0; in_lane_valid = 2'b00; in_instr = 64'd0;
        tick(); tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_data", {out_imm ^ out_btarget, 64'(out_lane_valid)}, 64'd0);
        chk("rst_imm", out_imm, 64'd0);
        chk("rst_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_regs", {34'd0, out_rd, out_rs1, out_rs2}, 64'd0);
        chk_sfb("rst", 2'b00, 2'b00);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        for (int v = 0; v < 7; v++) begin
            send(vecs[v].lv, vecs[v].pc, vecs[v].i0, vecs[v].i1);
            chk($sformatf("v%0d_out_valid", v), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d_lane_valid", v), 64'(out_lane_valid), 64'(vecs[v].lv));
            chk($sformatf("v%0d_legal", v), 64'({out_ctrl[1].legal, out_ctrl[0].legal}),
                64'(vecs[v].legal));
            chk($sformatf("v%0d_imm", v), out_imm, {vecs[v].imm1, vecs[v].imm0});
            chk($sformatf("v%0d_btarget", v), out_btarget, {vecs[v].bt1, vecs[v].bt0});
            chk($sformatf("v%0d_rd", v), 64'(out_rd), 64'(vecs[v].rd));
            chk_sfb($sformatf("v%0d", v), vecs[v].sh, vecs[v].sfb);
        end

        // Backpressure: first bundle held for three cycles while the second waits.
        tick();
        chk("drain_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        send(2'b11, 32'h0, ADDI5, LUI);
        in_valid = 1'b1; in_lane_valid = 2'b11; in_pc = 32'h8; in_instr = {XOR, ADD};
        for (int k = 0; k < 3; k++) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_imm_hold", out_imm, {32'h12345000, 32'd5});
            chk("bp_rd_hold", 64'(out_rd), 64'({5'd2, 5'd1}));
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", 64'(in_ready), 64'd1);
        chk("bp_imm_release", out_imm, {32'h12345000, 32'd5});
        tick();
        in_valid = 1'b0;
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        chk("bp_next_imm", out_imm, 64'd0);
        chk("bp_next_rd", 64'(out_rd), 64'({5'd4, 5'd3}));

        // Shadow spanning bundles.
        send(2'b11, 32'h800, ADD, BNE16);
        chk_sfb("xb_head", 2'b00, 2'b10);
        chk("xb_btarget", out_btarget, {32'h814, 32'd0});
        send(2'b11, 32'h808, ADD, XOR);
        chk_sfb("xb_second", 2'b11, 2'b00);
        send(2'b01, 32'h810, ADD, ADD);
        chk_sfb("xb_third", 2'b01, 2'b00);
        chk("xb_third_lanes", 64'(out_lane_valid), 64'd1);
        send(2'b11, 32'h814, ADD, ADD);
        chk_sfb("xb_after", 2'b00, 2'b00);

        // Load under shadow cancels it.
        send(2'b10, 32'h900, ADD, BEQ12);
        chk_sfb("cancel_head", 2'b00, 2'b10);
        send(2'b11, 32'h908, LW, ADD);
        chk_sfb("cancel_lw", 2'b00, 2'b00);
        send(2'b11, 32'h910, ADD, ADD);
        chk_sfb("cancel_after", 2'b00, 2'b00);

        // Branch under shadow cancels, then starts its own SFB.
        send(2'b11, 32'hA00, BEQ8, BEQ12);
        chk_sfb("rearm_heads", 2'b00, 2'b11);
        chk("rearm_btarget", out_btarget, {32'hA10, 32'hA08});
        send(2'b11, 32'hA08, ADD, ADD);
        chk_sfb("rearm_shadow", 2'b11, 2'b00);
        send(2'b11, 32'hA10, ADD, ADD);
        chk_sfb("rearm_after", 2'b00, 2'b00);

        // Flush with a pending shadow and a coincident bundle.
        send(2'b10, 32'hB00, ADD, BNE16);
        chk_sfb("flush_head", 2'b00, 2'b10);
        in_valid = 1'b1; in_lane_valid = 2'b11; in_pc = 32'hB08; in_instr = {ADD, ADD};
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_lane_valid", 64'(out_lane_valid), 64'd0);
        send(2'b11, 32'hB10, ADD, ADD);
        chk("flush_next_valid", 64'(out_valid), 64'd1);
        chk_sfb("flush_next", 2'b00, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised, pipelined successor to the single-instruction combinational decoder.
- Decodes a bundle of up to DECODE_WIDTH RV32I instructions per cycle from the fetch queue into one registered output stage feeding rename.
- Adds valid/ready flow control, flush, full 32-bit immediate expansion and per-lane branch target computation.
- Adds a stateful short-forward-branch (SFB) shadow tracker that persists across bundles.

Parameters:
- DECODE_WIDTH, 2, instructions decoded per cycle (1..4).
- MAX_SHADOW, 3, largest SFB shadow in instructions (branch offset ≤ 4*(MAX_SHADOW+1) bytes).
- CNT_W, 3, shadow counter width; must satisfy 2**CNT_W > MAX_SHADOW.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard output register and shadow state
- in_valid  in  1  fetch bundle valid
- in_ready  out  1  stage can accept bundle
- in_pc  in  32  PC of lane 0; lane i PC = in_pc + 4*i
- in_lane_valid  in  DECODE_WIDTH  per-lane instruction present
- in_instr  in  32*DECODE_WIDTH  instruction words, lane 0 in LSBs
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  rename accepts bundle
- out_lane_valid  out  DECODE_WIDTH  registered lane mask
- out_ctrl  out  DECODE_WIDTH x ctrl_t  decoded control (legal, uop, exu, reg-use flags, imm type)
- out_rd/out_rs1/out_rs2  out  5*DECODE_WIDTH each  register fields
- out_imm  out  32*DECODE_WIDTH  sign-extended immediate per imm type (R-type: 0)
- out_btarget  out  32*DECODE_WIDTH  pc+b_imm for branches, pc+j_imm for JAL, else 0
- out_shadowed  out  DECODE_WIDTH  lane executes predicated under an SFB
- out_sfb  out  DECODE_WIDTH  lane is an SFB head

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: out_valid=0; all out_* data=0; shadow_cnt=0. in_ready is 1 after reset.
- Handshake: in_ready = !out_valid | out_ready. A bundle is accepted when in_valid & in_ready and appears on outputs the next cycle (latency 1).
- Output holds stable while out_valid & !out_ready.
- Lanes: lanes with in_lane_valid=0 register lane_valid=0 and all-zero fields, and do not affect shadow state.
- SFB head: a conditional branch (bctrl branch flag) with b_imm in (4, 4*(MAX_SHADOW+1)]. Such a lane sets out_sfb=1 and loads shadow_cnt = b_imm/4 - 1.
- Shadow evaluation runs lane 0 upward within the bundle, carrying the running count.
  - Lane under shadow (count>0) that is shadowable: out_shadowed=1, count decrements.
  - Lane under shadow that is not shadowable: count cleared to 0, out_shadowed=0.
  - A branch under shadow is non-shadowable, so it cancels the current shadow first, then may start a new SFB.
- Shadow commit: shadow_cnt register updates only on an accepted bundle, to the count remaining after the last valid lane. A shadow spans bundle boundaries.
- b_imm ≤ 4 (including backward branches): not an SFB; count unchanged by the branch itself.
- Flush: next cycle out_valid=0 and shadow_cnt=0; any bundle presented in the same cycle is dropped. Flush takes priority over accept and over reset-free hold.
- Illegal instruction: ctrl.legal=0 is passed through as-is and the lane is treated as non-shadowable.
- Immediates: packed-immediate muxing is replaced by full expansion for I, S, B, U and J types. ADD-style R-type yields 0.

Optional Feature:
- Macro: DECODE_SFB_EN.
- Defined: shadow tracker is present as described above.
- Undefined: no shadow_cnt register; out_shadowed and out_sfb are tied to 0; all other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → out_valid=0, in_ready=1, all outputs 0.
- Backpressure: W=2, ADDI x1,x0,5 / LUI x2,0x12345 accepted while out_ready=0 for 3 cycles → outputs held, in_ready=0. Then out_ready=1 → next bundle accepted, out_imm lane0=5, lane1=0x12345000.
- In-bundle SFB: W=2 at pc=0x100, lanes BEQ x1,x2,+8 / ADDI → lane0 out_sfb=1, out_btarget=0x108; lane1 out_shadowed=1; shadow_cnt=0 afterward.
- Cross-bundle shadow: BNE +16 in lane 1, next bundle ADD/XOR → count 3→1 after the second bundle, both lanes shadowed. A third bundle with lane0 ADD → shadowed, count 0.
- Cancel: shadow count 2, next lane is LW → out_shadowed=0, count cleared, following ADD not shadowed.
- Flush: flush=1 coincident with in_valid and a pending shadow count → next cycle out_valid=0, and the following ADD is not shadowed. With DECODE_SFB_EN undefined, the SFB case yields out_sfb=0 and out_shadowed=0.
